// File: rtl/load_writeback_if.sv
// load_writeback_if: execute load, data-memory and register-file write signals
interface load_writeback_if #(
  parameter int DataWidth    = 32,
  parameter int AddrWidth    = 32,
  parameter int AddrRegWidth = 5
);
  logic                    ld_valid;
  logic                    ld_ready;
  logic [AddrWidth-1:0]    ld_addr;
  logic [2:0]              ld_funct3;
  logic [AddrRegWidth-1:0] ld_rd;
  logic                    ld_exc;
  logic                    busy;
  logic                    mem_req;
  logic [AddrWidth-1:0]    mem_addr;
  logic                    mem_gnt;
  logic                    mem_rvalid;
  logic [DataWidth-1:0]    mem_rdata;
  logic [AddrRegWidth-1:0] rd;
  logic                    wen;
  logic [DataWidth-1:0]    wdata;
  modport master (
    output ld_valid, ld_addr, ld_funct3, ld_rd, mem_gnt, mem_rvalid, mem_rdata,
    input  ld_ready, ld_exc, busy, mem_req, mem_addr, rd, wen, wdata
  );
  modport slave (
    input  ld_valid, ld_addr, ld_funct3, ld_rd, mem_gnt, mem_rvalid, mem_rdata,
    output ld_ready, ld_exc, busy, mem_req, mem_addr, rd, wen, wdata
  );
endinterface

// File: rtl/load_writeback.sv
// load_writeback: one-at-a-time load sequencer from execute to the register-file write port
module load_writeback #(
  parameter int DataWidth    = 32,
  parameter int AddrWidth    = 32,
  parameter int AddrRegWidth = 5
) (
  input logic             clk,
  input logic             rst,
  load_writeback_if.slave bus
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, WB} state_e;
  state_e                  state_q, state_d;
  logic [1:0]              lane_q, lane_d;
  logic [2:0]              f3_q, f3_d;
  logic [AddrRegWidth-1:0] lrd_q, lrd_d, rd_q, rd_d;
  logic [AddrWidth-1:0]    mem_addr_q, mem_addr_d;
  logic [DataWidth-1:0]    wdata_q, wdata_d, fmt;
  logic                    mem_req_q, mem_req_d, wen_q, wen_d, exc_q, exc_d, bad;
  logic [7:0]              b;
  logic [15:0]             h;
  always_comb begin
    bad = bus.ld_funct3 == 3'b011 || bus.ld_funct3[2:1] == 2'b11 ||
          (bus.ld_funct3[1:0] == 2'b01 && bus.ld_addr[0]) ||
          (bus.ld_funct3[1:0] == 2'b10 && bus.ld_addr[1:0] != 2'b00);
    b   = bus.mem_rdata[{lane_q, 3'b000} +: 8];
    h   = lane_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
    fmt = f3_q[1] ? bus.mem_rdata :
          f3_q[0] ? {{(DataWidth-16){~f3_q[2] & h[15]}}, h} :
                    {{(DataWidth-8){~f3_q[2] & b[7]}}, b};
  end
  always_comb begin
    state_d    = state_q;
    lane_d     = lane_q;
    f3_d       = f3_q;
    lrd_d      = lrd_q;
    rd_d       = rd_q;
    mem_addr_d = mem_addr_q;
    wdata_d    = wdata_q;
    wen_d      = 1'b0;
    exc_d      = 1'b0;
    case (state_q)
      IDLE: if (bus.ld_valid) begin
        exc_d   = bad;
        state_d = bad ? IDLE : REQ;
        if (!bad) begin
          lane_d     = bus.ld_addr[1:0];
          f3_d       = bus.ld_funct3;
          lrd_d      = bus.ld_rd;
          mem_addr_d = {bus.ld_addr[AddrWidth-1:2], 2'b00};
        end
      end
      REQ:  state_d = bus.mem_gnt ? WAIT : REQ;
      WAIT: if (bus.mem_rvalid) begin
        state_d = WB;
        wdata_d = fmt;
        rd_d    = lrd_q;
        wen_d   = |lrd_q;
      end
      default: state_d = IDLE;
    endcase
    mem_req_d = state_d == REQ;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      lane_q     <= '0;
      f3_q       <= '0;
      lrd_q      <= '0;
      rd_q       <= '0;
      mem_addr_q <= '0;
      wdata_q    <= '0;
      mem_req_q  <= 1'b0;
      wen_q      <= 1'b0;
      exc_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      lane_q     <= lane_d;
      f3_q       <= f3_d;
      lrd_q      <= lrd_d;
      rd_q       <= rd_d;
      mem_addr_q <= mem_addr_d;
      wdata_q    <= wdata_d;
      mem_req_q  <= mem_req_d;
      wen_q      <= wen_d;
      exc_q      <= exc_d;
    end
  end
  assign bus.ld_ready = state_q == IDLE;
  assign bus.busy     = state_q != IDLE;
  assign bus.mem_req  = mem_req_q;
  assign bus.mem_addr = mem_addr_q;
  assign bus.rd       = rd_q;
  assign bus.wen      = wen_q;
  assign bus.wdata    = wdata_q;
  assign bus.ld_exc   = exc_q;
endmodule

// File: tb/tb_load_writeback.sv
// tb_load_writeback: directed load vectors with hand-computed results
module tb_load_writeback;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;
  load_writeback_if bus ();
  load_writeback dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic run_load(input logic [31:0] a, input logic [2:0] f3, input logic [4:0] r,
                          input logic [31:0] data, input int gd, input int rvd,
                          input logic [31:0] expw, input logic expwen);
    bus.ld_valid = 1'b1; bus.ld_addr = a; bus.ld_funct3 = f3; bus.ld_rd = r;
    tick;
    bus.ld_valid = 1'b0;
    chk("req_t1", 32'(bus.mem_req), 1);
    chk("ready_t1", 32'(bus.ld_ready), 0);
    chk("busy_t1", 32'(bus.busy), 1);
    chk("exc_t1", 32'(bus.ld_exc), 0);
    chk("maddr_t1", bus.mem_addr, {a[31:2], 2'b00});
    for (int i = 0; i < gd; i++) begin
      bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h5A5A5A5A;
      tick;
      chk("req_stall", 32'(bus.mem_req), 1);
      chk("maddr_stall", bus.mem_addr, {a[31:2], 2'b00});
      chk("wen_stall", 32'(bus.wen), 0);
    end
    bus.mem_gnt = 1'b1; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hA5A5A5A5;
    tick;
    bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0;
    chk("req_wait", 32'(bus.mem_req), 0);
    chk("wen_wait", 32'(bus.wen), 0);
    for (int i = 0; i < rvd; i++) begin
      tick;
      chk("wen_rvstall", 32'(bus.wen), 0);
      chk("busy_rvstall", 32'(bus.busy), 1);
    end
    bus.mem_rvalid = 1'b1; bus.mem_rdata = data;
    tick;
    bus.mem_rvalid = 1'b0; bus.mem_rdata = 32'h0;
    chk("wen_wb", 32'(bus.wen), 32'(expwen));
    chk("exc_wb", 32'(bus.ld_exc), 0);
    chk("ready_wb", 32'(bus.ld_ready), 0);
    if (expwen) begin
      chk("rd_wb", 32'(bus.rd), 32'(r));
      chk("wdata_wb", bus.wdata, expw);
    end
    tick;
    chk("wen_after", 32'(bus.wen), 0);
    chk("ready_after", 32'(bus.ld_ready), 1);
    chk("busy_after", 32'(bus.busy), 0);
  endtask
  task automatic reject(input logic [31:0] a, input logic [2:0] f3);
    bus.ld_valid = 1'b1; bus.ld_addr = a; bus.ld_funct3 = f3; bus.ld_rd = 5'd9;
    tick;
    bus.ld_valid = 1'b0;
    chk("exc_rej", 32'(bus.ld_exc), 1);
    chk("req_rej", 32'(bus.mem_req), 0);
    chk("wen_rej", 32'(bus.wen), 0);
    chk("ready_rej", 32'(bus.ld_ready), 1);
    chk("busy_rej", 32'(bus.busy), 0);
  endtask
  initial begin
    bus.ld_valid = 1'b0; bus.ld_addr = '0; bus.ld_funct3 = '0; bus.ld_rd = '0;
    bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
    #12;
    chk("rst_req", 32'(bus.mem_req), 0);
    chk("rst_wen", 32'(bus.wen), 0);
    chk("rst_exc", 32'(bus.ld_exc), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_rd", 32'(bus.rd), 0);
    chk("rst_wdata", bus.wdata, 0);
    chk("rst_maddr", bus.mem_addr, 0);
    tick;
    rst = 1'b1;
    tick;
    chk("ready_init", 32'(bus.ld_ready), 1);
    run_load(32'h100, 3'b010, 5'd3, 32'hDEADBEEF, 0, 0, 32'hDEADBEEF, 1'b1);
    run_load(32'h103, 3'b000, 5'd4, 32'h80112233, 0, 0, 32'hFFFFFF80, 1'b1);
    run_load(32'h103, 3'b100, 5'd5, 32'h80112233, 0, 0, 32'h00000080, 1'b1);
    run_load(32'h202, 3'b001, 5'd6, 32'h9ABC1234, 0, 0, 32'hFFFF9ABC, 1'b1);
    run_load(32'h200, 3'b101, 5'd8, 32'h9ABC1234, 0, 0, 32'h00001234, 1'b1);
    run_load(32'h201, 3'b000, 5'd10, 32'h00007F00, 0, 0, 32'h0000007F, 1'b1);
    reject(32'h101, 3'b010);
    run_load(32'h400, 3'b010, 5'd11, 32'h01020304, 0, 0, 32'h01020304, 1'b1);
    reject(32'h001, 3'b001);
    run_load(32'h402, 3'b101, 5'd12, 32'hF00D0000, 0, 0, 32'h0000F00D, 1'b1);
    reject(32'h000, 3'b011);
    run_load(32'h000, 3'b010, 5'd13, 32'h11111111, 0, 0, 32'h11111111, 1'b1);
    reject(32'h000, 3'b110);
    tick;
    chk("exc_one_cycle", 32'(bus.ld_exc), 0);
    run_load(32'h300, 3'b010, 5'd7, 32'h13572468, 3, 2, 32'h13572468, 1'b1);
    run_load(32'h005, 3'b100, 5'd0, 32'h0000AA00, 1, 1, 32'h000000AA, 1'b0);
    bus.ld_valid = 1'b1; bus.ld_addr = 32'h500; bus.ld_funct3 = 3'b010; bus.ld_rd = 5'd15;
    tick;
    bus.ld_valid = 1'b0; bus.mem_gnt = 1'b1;
    tick;
    bus.mem_gnt = 1'b0;
    chk("wait_busy", 32'(bus.busy), 1);
    rst = 1'b0;
    #1;
    chk("arst_busy", 32'(bus.busy), 0);
    chk("arst_wdata", bus.wdata, 0);
    chk("arst_rd", 32'(bus.rd), 0);
    chk("arst_maddr", bus.mem_addr, 0);
    tick;
    rst = 1'b1;
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hCAFEF00D;
    tick;
    tick;
    bus.mem_rvalid = 1'b0;
    chk("stale_wen", 32'(bus.wen), 0);
    chk("stale_ready", 32'(bus.ld_ready), 1);
    chk("stale_wdata", bus.wdata, 0);
    chk("stale_req", 32'(bus.mem_req), 0);
    run_load(32'h600, 3'b001, 5'd1, 32'h00008001, 0, 0, 32'hFFFF8001, 1'b1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/load_writeback.md
# load_writeback

Load-path sequencer between the execute stage and the register-file write port of the RV32I core. It accepts one load at a time from execute, issues a word-aligned read on the data-memory request/grant interface, and waits for the response. It then extracts and sign- or zero-extends the addressed byte, halfword or word, and drives one register-file write (rd, wen, wdata). Misaligned or illegal loads are rejected with an exception pulse and never touch memory or the register file.

## Interface
- DataWidth, 32, register and memory data width
- AddrWidth, 32, byte address width
- AddrRegWidth, 5, register index width
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous and active-low (0 = reset)
- ld_valid  in  1  execute presents a load
- ld_ready  out  1  unit can accept a load (1 only in IDLE)
- ld_addr  in  AddrWidth  byte address of the load
- ld_funct3  in  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
- ld_rd  in  AddrRegWidth  destination register
- ld_exc  out  1  one-cycle pulse: misaligned or illegal load rejected
- busy  out  1  transaction in flight (state != IDLE)
- mem_req  out  1  memory read request
- mem_addr  out  AddrWidth  request address, {ld_addr[AddrWidth-1:2], 2'b00}
- mem_gnt  in  1  memory accepted the request this cycle
- mem_rvalid  in  1  read data valid
- mem_rdata  in  DataWidth  read word
- rd  out  AddrRegWidth  register-file write index
- wen  out  1  register-file write enable, one cycle per load
- wdata  out  DataWidth  register-file write data

## Operation
- States: IDLE, REQ, WAIT, WB.
- IDLE:
  - ld_ready=1.
  - When ld_valid=1, latch addr, funct3 and rd.
  - Misaligned or illegal load → ld_exc=1 next cycle; stay IDLE.
    - Misaligned: LH/LHU with addr[0]=1, or LW with addr[1:0]≠00.
    - Illegal: funct3 ∈ {011, 110, 111}.
  - Otherwise → REQ.
- REQ:
  - mem_req=1 and mem_addr held stable until mem_gnt.
  - When mem_gnt=1 → WAIT.
- WAIT:
  - mem_req=0.
  - When mem_rvalid=1, register the formatted data → WB.
  - mem_rvalid is ignored in every state except WAIT.
- Data formatting (byte lane = addr[1:0]):
  - LB/LBU select byte lane; LH/LHU select halfword addr[1].
  - LB/LH sign-extend to 32 bits; LBU/LHU zero-extend; LW passes the word.
- WB:
  - wen=1 for exactly one cycle with rd and wdata; then → IDLE.
  - If latched rd=0, wen=0 in WB; the FSM still spends the WB cycle.
- Outside WB: wen=0; rd and wdata hold their last values.
- ld_exc and wen are never asserted in the same cycle.

## Timing
- Reset (rst=0, async):
  - State→IDLE.
  - mem_req, wen, ld_exc, busy = 0; rd, wdata, mem_addr = 0.
  - ld_ready=1 once reset is released.
  - Reset mid-transaction abandons the load with no write; a later stale mem_rvalid is ignored.
- Accept cycle T (ld_valid & ld_ready):
  - mem_req=1 at T+1.
  - With mem_gnt at T+1, mem_rvalid at T+2 at the earliest, wen at T+3.
  - Minimum accept-to-wen latency is 3 cycles; each grant or rvalid stall cycle adds 1.
- Throughput: at most one load per 4 cycles; ld_ready=0 from T+1 until the cycle after WB.
- Rejected load: ld_exc high at T+1 only; ld_ready remains 1, so a new load may be accepted at T+1.
- Memory side:
  - mem_rvalid in the same cycle as mem_gnt is not legal and is ignored.
  - mem_req never deasserts before mem_gnt.

## Test plan
- LW addr 0x100, mem_rdata=0xDEADBEEF, gnt immediate, rvalid next cycle → wen at T+3, rd=ld_rd, wdata=0xDEADBEEF, mem_addr=0x100.
- LB addr 0x103 and LBU addr 0x103, rdata=0x80112233 → wdata=0xFFFFFF80 and 0x00000080 respectively; mem_addr=0x100.
- LH addr 0x202, rdata=0x9ABC1234 → wdata=0xFFFF9ABC; LHU addr 0x200 → 0x00001234.
- LW addr 0x101, LH addr 0x001, funct3=011 → each gives a single ld_exc pulse, mem_req=0, wen=0, and a new load is accepted the next cycle.
- mem_gnt delayed 3 cycles and rvalid delayed 2 → mem_addr stable throughout, exactly one wen; ld_rd=0 → wen stays 0 and the FSM still returns to IDLE.
- rst=0 while in WAIT, then a stale rvalid after release → no wen; outputs at reset values, ld_ready=1.
